instruction_fetch: RTL and testbench

- Sequencer on the PC-facing side of the fetch path: drives the program counter's load/jump controls and consumes its PC value.
- Fetches one 32-bit word per PC from instruction memory using a req/ack handshake, then presents it to decode with valid/ready.
- Accepts branch/jump redirects from execute, converts them into a PC jump, and discards wrong-path fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding
// and the default boot address.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch sequencer: steers the external PC, fetches one word per PC over a
// req/ack bus and hands it to decode over valid/ready, honouring redirects.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          TIMEOUT      = 256,
    parameter int          CNT_W        = 9
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_PC,
    output logic        o_load_PC,
    output logic        o_jump_DV,
    output logic [31:0] o_jump_address,
    output logic        o_mem_rd,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_ack,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_PC,
    output logic        o_instr_DV,
    input  logic        i_instr_ready,
    input  logic        i_redirect_DV,
    input  logic [31:0] i_redirect_addr,
    output logic        o_fetch_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_r;
    fetch_state_e     state_s;
    logic             pending_vld_r;
    logic [31:0]      pending_addr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;

    // A fetch is only kept when no redirect is pending or arriving with the ack.
    assign accept_s = (state_r == ST_REQ) && i_mem_ack && !pending_vld_r && !i_redirect_DV;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    state_s = accept_s ? ST_VALID : ST_LOAD;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_VALID: begin
                if (i_redirect_DV || i_instr_ready) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_VALID;
                end
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_ERR;
            end
        endcase
    end

    // Output decode; the reset state is LOAD, so the PC is loaded out of reset.
    always_comb begin
        o_load_PC      = 1'b0;
        o_jump_DV      = 1'b0;
        o_jump_address = 32'h0000_0000;
        o_mem_rd       = 1'b0;
        o_mem_addr     = 32'h0000_0000;
        o_fetch_err    = 1'b0;
        case (state_r)
            ST_LOAD: begin
                o_load_PC      = 1'b1;
                o_jump_DV      = pending_vld_r;
                o_jump_address = pending_addr_r;
            end
            ST_REQ: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = i_PC;
            end
            ST_VALID: begin
                o_mem_rd = 1'b0;
            end
            ST_ERR: begin
                o_fetch_err = 1'b1;
            end
            default: begin
                o_fetch_err = 1'b1;
            end
        endcase
    end

    // Pending redirect: a redirect arriving in LOAD outlives that LOAD's clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_vld_r  <= 1'b1;
            pending_addr_r <= RESET_VECTOR;
        end else if (i_redirect_DV && (state_r != ST_ERR)) begin
            pending_vld_r  <= 1'b1;
            pending_addr_r <= i_redirect_addr;
        end else if (state_r == ST_LOAD) begin
            pending_vld_r  <= 1'b0;
        end else begin
            pending_vld_r  <= pending_vld_r;
        end
    end

    // Ack timeout counter, running only while a request is outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Decode-facing instruction register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr    <= 32'h0000_0000;
            o_instr_PC <= 32'h0000_0000;
            o_instr_DV <= 1'b0;
        end else begin
            if (accept_s) begin
                o_instr    <= i_mem_data;
                o_instr_PC <= i_PC;
            end
            o_instr_DV <= (state_s == ST_VALID);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a cycle-by-cycle vector table plus
// hand-written reset sequences; the bench itself models the program counter.
module tb_instruction_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_PC;
    logic        o_load_PC;
    logic        o_jump_DV;
    logic [31:0] o_jump_address;
    logic        o_mem_rd;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_data = 32'h0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_instr_PC;
    logic        o_instr_DV;
    logic        i_instr_ready = 1'b0;
    logic        i_redirect_DV = 1'b0;
    logic [31:0] i_redirect_addr = 32'h0;
    logic        o_fetch_err;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic        load;
        logic        jdv;
        logic [31:0] jaddr;
        logic        rd;
        logic [31:0] maddr;
        logic        dv;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        err;
    } out_t;

    typedef struct {
        logic        redir;
        logic [31:0] raddr;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch #(
        .RESET_VECTOR(32'h0000_0100),
        .TIMEOUT     (8),
        .CNT_W       (9)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_PC           (i_PC),
        .o_load_PC      (o_load_PC),
        .o_jump_DV      (o_jump_DV),
        .o_jump_address (o_jump_address),
        .o_mem_rd       (o_mem_rd),
        .o_mem_addr     (o_mem_addr),
        .i_mem_data     (i_mem_data),
        .i_mem_ack      (i_mem_ack),
        .o_instr        (o_instr),
        .o_instr_PC     (o_instr_PC),
        .o_instr_DV     (o_instr_DV),
        .i_instr_ready  (i_instr_ready),
        .i_redirect_DV  (i_redirect_DV),
        .i_redirect_addr(i_redirect_addr),
        .o_fetch_err    (o_fetch_err)
    );

    always #5 i_clk = ~i_clk;

    // Program counter model: no reset, loads on strobe.
    logic [31:0] pc_model = 32'h0;
    always @(posedge i_clk) begin
        if (o_load_PC) pc_model <= o_jump_DV ? o_jump_address : pc_model + 32'd4;
    end
    assign i_PC = pc_model;

    function automatic out_t mk(input logic load, input logic jdv, input logic [31:0] jaddr,
                                input logic rd, input logic [31:0] maddr, input logic dv,
                                input logic [31:0] instr, input logic [31:0] ipc, input logic err);
        out_t o;
        o.load = load; o.jdv = jdv; o.jaddr = jaddr; o.rd = rd; o.maddr = maddr;
        o.dv = dv; o.instr = instr; o.ipc = ipc; o.err = err;
        return o;
    endfunction

    task automatic add(input logic redir, input logic [31:0] raddr, input logic ack,
                       input logic [31:0] data, input logic ready, input out_t exp);
        vec_t v;
        v.redir = redir; v.raddr = raddr; v.ack = ack; v.data = data; v.ready = ready; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = mk(o_load_PC, o_jump_DV, o_jump_address, o_mem_rd, o_mem_addr,
                 o_instr_DV, o_instr, o_instr_PC, o_fetch_err);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got load=%b jdv=%b jaddr=%h rd=%b maddr=%h dv=%b instr=%h ipc=%h err=%b want load=%b jdv=%b jaddr=%h rd=%b maddr=%h dv=%b instr=%h ipc=%h err=%b",
                     name, got.load, got.jdv, got.jaddr, got.rd, got.maddr, got.dv, got.instr, got.ipc, got.err,
                     exp.load, exp.jdv, exp.jaddr, exp.rd, exp.maddr, exp.dv, exp.instr, exp.ipc, exp.err);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] raddr, input logic ack,
                         input logic [31:0] data, input logic ready);
        i_redirect_DV = redir; i_redirect_addr = raddr; i_mem_ack = ack;
        i_mem_data = data; i_instr_ready = ready;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] I1 = 32'h0050_0093, I2 = 32'hAAAA_0001, I3 = 32'h1111_0001;
    localparam logic [31:0] I4 = 32'h2222_0002, I5 = 32'h3333_0003, I6 = 32'h6666_0006;
    localparam logic [31:0] I7 = 32'h4444_0004;

    initial begin
        // Reset vector, then a fetch with two wait cycles.
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));
        add(1'b0, 32'h0, 1'b1, I1,    1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I1, 32'h100, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, I1, 32'h100, 1'b0));
        // Zero-wait fetch at PC+4, then five cycles of backpressure.
        add(1'b0, 32'h0, 1'b1, I2,    1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, I1, 32'h100, 1'b0));
        for (int i = 0; i < 5; i++)
            add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, I2, 32'h104, 1'b0));
        // Redirect while waiting; ack three cycles later is discarded.
        add(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b1, 32'hDEAD_DEAD, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, I2, 32'h104, 1'b0));
        add(1'b0, 32'h0, 1'b1, I3,    1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, I2, 32'h104, 1'b0));
        // Redirect in VALID with ready, then another redirect during LOAD.
        add(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I3, 32'h200, 1'b0));
        add(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, I3, 32'h200, 1'b0));
        add(1'b0, 32'h0, 1'b1, I4,    1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, I3, 32'h200, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, I3, 32'h200, 1'b0));
        add(1'b0, 32'h0, 1'b1, I5,    1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, I3, 32'h200, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I5, 32'h400, 1'b0));
        add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b1, 1'b0, 32'h400, 1'b0, 32'h0, 1'b0, I5, 32'h400, 1'b0));
        // Timeout: eight REQ cycles without ack, then sticky error.
        for (int i = 0; i < 8; i++)
            add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h404, 1'b0, I5, 32'h400, 1'b0));
        add(1'b1, 32'h500, 1'b1, I6, 1'b1, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, I5, 32'h400, 1'b1));
        for (int i = 0; i < 2; i++)
            add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, I5, 32'h400, 1'b1));

        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge i_clk);
            drive(vecs[i].redir, vecs[i].raddr, vecs[i].ack, vecs[i].data, vecs[i].ready);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset out of ERR, with a late ack during the first LOAD.
        @(negedge i_clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1 check("rst_from_err", mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        #1 check("late_ack_load", mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        @(negedge i_clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 check("late_ack_req", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));

        // Asynchronous reset mid-fetch, then a zero-wait 3-cycle fetch.
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check("rst_midfetch", mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 check("rst_release", mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        @(negedge i_clk);
        drive(1'b0, 32'h0, 1'b1, I7, 1'b0);
        #1 check("zw_req", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));
        @(negedge i_clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1 check("zw_valid", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, I7, 32'h100, 1'b0));
        @(negedge i_clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 check("zw_load", mk(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, I7, 32'h100, 1'b0));
        @(negedge i_clk);
        #1 check("zw_next_req", mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, I7, 32'h100, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
